// File: rtl/dco_cal_ctrl.sv
// Closed-loop DCO calibration: sweeps every alpha code, measures MEAS_PERIODS DCO periods
// in clk cycles, keeps the code closest to the target and then parks the DCO on it.
module dco_cal_ctrl #(
  parameter int NUM_CODES    = 4,
  parameter int MEAS_PERIODS = 16,
  parameter int CNT_W        = 16,
  parameter int SETTLE_CYC   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic             dco_clk_in,
  output logic             en,
  output logic [6:0]       alpha,
  output logic             busy,
  output logic             done,
  output logic [6:0]       best_alpha,
  output logic [CNT_W-1:0] best_err,
  output logic             timeout
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int EW = $clog2(MEAS_PERIODS + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [EW-1:0]    EDGE_LAST   = EW'(MEAS_PERIODS - 1);
  localparam logic [6:0]       LAST_CODE   = 7'(NUM_CODES - 1);
  localparam logic [6:0]       OFF_CODE    = 7'(NUM_CODES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {IDLE, SETTLE, SYNC, MEAS, EVAL, DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Difference is formed one bit wider so the magnitude of any CNT_W-bit pair fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] abs_err(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return CNT_W'(diff[CNT_W] ? -diff : diff);
  endfunction

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [SW-1:0]    settle_q;
  logic [EW-1:0]    edge_q;
  logic [CNT_W-1:0] cnt_q, target_q;
  logic [6:0]       k_q;
  logic             sat_q;
  logic             en_q, busy_q, done_q, timeout_q;
  logic [6:0]       alpha_q, best_alpha_q;
  logic [CNT_W-1:0] best_err_q;

  logic             dco_rise;
  logic [CNT_W-1:0] cnt_d, err_d, best_err_d;
  logic [6:0]       best_alpha_d;
  logic             better_d;

  assign dco_rise     = s2_q & ~s3_q;
  assign cnt_d        = sat_inc(cnt_q);
  assign err_d        = sat_q ? CNT_MAX : abs_err(cnt_q, target_q);
  // Strict compare: on a tie the earlier (lower) code is kept.
  assign better_d     = err_d < best_err_q;
  assign best_err_d   = better_d ? err_d : best_err_q;
  assign best_alpha_d = better_d ? k_q : best_alpha_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      settle_q     <= '0;
      edge_q       <= '0;
      cnt_q        <= '0;
      target_q     <= '0;
      k_q          <= '0;
      sat_q        <= 1'b0;
      en_q         <= 1'b0;
      alpha_q      <= OFF_CODE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_alpha_q <= '0;
      best_err_q   <= CNT_MAX;
      timeout_q    <= 1'b0;
    end else begin
      s1_q   <= dco_clk_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            target_q   <= target_cnt;
            k_q        <= '0;
            alpha_q    <= '0;
            en_q       <= 1'b1;
            best_err_q <= CNT_MAX;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b1;
            settle_q   <= '0;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= SYNC;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SYNC: begin
          // A DCO that never toggles is caught by the same saturating counter as a slow one.
          if (cnt_q == CNT_MAX) begin
            sat_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= EVAL;
          end else if (dco_rise) begin
            cnt_q   <= '0;
            edge_q  <= '0;
            state_q <= MEAS;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        MEAS: begin
          if (cnt_q == CNT_MAX) begin
            sat_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= EVAL;
          end else begin
            cnt_q <= cnt_d;
            if (dco_rise) begin
              if (edge_q == EDGE_LAST) state_q <= EVAL;
              else                     edge_q  <= edge_q + 1'b1;
            end
          end
        end
        EVAL: begin
          best_err_q   <= best_err_d;
          best_alpha_q <= best_alpha_d;
          if (k_q == LAST_CODE) begin
            alpha_q <= best_alpha_d;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q      <= k_q + 7'd1;
            alpha_q  <= k_q + 7'd1;
            settle_q <= '0;
            state_q  <= SETTLE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en         = en_q;
  assign alpha      = alpha_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_alpha = best_alpha_q;
  assign best_err   = best_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_dco_cal_ctrl.sv
// Bench for dco_cal_ctrl: behavioural ring DCO (periods 10..13 clk cycles per code),
// table of sweeps checked through a scoreboard, plus reset and restart corner cases.
module tb_dco_cal_ctrl;

  localparam int CW   = 10;
  localparam int MAXE = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, dco_clk;
  logic [CW-1:0] target_cnt;
  logic          en, busy, done, timeout;
  logic [6:0]    alpha, best_alpha;
  logic [CW-1:0] best_err;

  int errors = 0;
  int checks = 0;
  int stuck_code = -1;
  bit jitter_on = 1'b0;
  int per_tab [4] = '{10, 11, 12, 13};

  typedef struct {
    int target;
    int stuck;
    bit jit;
    bit restart;
    int exp_alpha;
    int exp_err;
    int tol;
    bit exp_to;
  } vec_t;

  vec_t vecs [11];
  vec_t sb_q [$];

  dco_cal_ctrl #(.NUM_CODES(4), .MEAS_PERIODS(16), .CNT_W(CW), .SETTLE_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt), .dco_clk_in(dco_clk),
    .en(en), .alpha(alpha), .busy(busy), .done(done), .best_alpha(best_alpha),
    .best_err(best_err), .timeout(timeout)
  );

  always #50 clk = ~clk;

  // DCO edges sit 3 units off the 10-unit grid so they never coincide with a clk edge.
  initial begin : dco_model
    int p, jp, jn;
    jp = 0;
    dco_clk = 1'b0;
    #3;
    forever begin
      if (en !== 1'b1 || alpha > 7'd3 || int'(alpha) == stuck_code) begin
        dco_clk = 1'b0;
        #10;
      end else begin
        p  = per_tab[alpha[1:0]];
        jn = jitter_on ? int'(10 * $urandom_range(0, 8)) : 0;
        dco_clk = 1'b1;
        #(p * 50);
        dco_clk = 1'b0;
        #(p * 50 - jp + jn);
        jp = jn;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic run_sweep(input vec_t v, input string tag);
    int         seq_act, seq_exp, busy_low, en_low, extra;
    bit         poked, got;
    logic [6:0] last;
    vec_t       e;
    stuck_code = v.stuck;
    jitter_on  = v.jit;
    @(negedge clk);
    target_cnt = CW'(v.target);
    start      = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_on_start"}, 32'(busy), 1);
    last     = alpha;
    seq_act  = int'(alpha);
    busy_low = 0;
    en_low   = 0;
    poked    = 1'b0;
    got      = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (alpha !== last) begin
        seq_act = seq_act * 8 + int'(alpha);
        last    = alpha;
      end
      if (busy !== 1'b1) busy_low++;
      if (en !== 1'b1) en_low++;
      if (v.restart && !poked && alpha == 7'd2) begin
        target_cnt = '0;
        start      = 1'b1;
        poked      = 1'b1;
      end
    end
    e = sb_q.pop_front();
    chk({tag, " done_wait"}, 32'(got), 1);
    if (!got) return;
    if (alpha !== last) seq_act = seq_act * 8 + int'(alpha);
    seq_exp = ((1 * 8) + 2) * 8 + 3;
    if (e.exp_alpha != 3) seq_exp = seq_exp * 8 + e.exp_alpha;
    chk({tag, " best_alpha"}, 32'(best_alpha), e.exp_alpha);
    chk_near({tag, " best_err"}, int'(best_err), e.exp_err, e.tol);
    chk({tag, " timeout"}, 32'(timeout), 32'(e.exp_to));
    chk({tag, " busy_at_done"}, 32'(busy), 0);
    chk({tag, " alpha_at_done"}, 32'(alpha), e.exp_alpha);
    chk({tag, " alpha_seq"}, seq_act, seq_exp);
    chk({tag, " busy_low_cycles"}, busy_low, 0);
    chk({tag, " en_low_cycles"}, en_low, 0);
    @(negedge clk);
    chk({tag, " done_width"}, 32'(done), 0);
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk({tag, " extra_done"}, extra, 0);
    chk({tag, " alpha_hold"}, 32'(alpha), e.exp_alpha);
    chk({tag, " en_hold"}, 32'(en), 1);
  endtask

  initial begin
    int  dcount;
    bit  got;
    rst        = 1'b1;
    start      = 1'b0;
    target_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst en", 32'(en), 0);
    chk("rst alpha", 32'(alpha), 4);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst best_alpha", 32'(best_alpha), 0);
    chk("rst best_err", 32'(best_err), MAXE);
    chk("rst timeout", 32'(timeout), 0);
    rst = 1'b0;

    // Counts per code are 160/176/192/208. Fields: target, stuck, jit, restart, alpha, err, tol, to
    vecs[0]  = '{180, -1, 1'b0, 1'b0, 1, 4,   0, 1'b0};
    vecs[1]  = '{184, -1, 1'b0, 1'b0, 1, 8,   0, 1'b0};
    vecs[2]  = '{180,  2, 1'b0, 1'b0, 1, 4,   0, 1'b1};
    vecs[3]  = '{200,  2, 1'b0, 1'b0, 3, 8,   0, 1'b1};
    vecs[4]  = '{160, -1, 1'b0, 1'b0, 0, 0,   0, 1'b0};
    vecs[5]  = '{192, -1, 1'b0, 1'b0, 2, 0,   0, 1'b0};
    vecs[6]  = '{1023,-1, 1'b0, 1'b0, 3, 815, 0, 1'b0};
    vecs[7]  = '{0,   -1, 1'b0, 1'b0, 0, 160, 0, 1'b0};
    vecs[8]  = '{180, -1, 1'b0, 1'b1, 1, 4,   0, 1'b0};
    vecs[9]  = '{180, -1, 1'b1, 1'b0, 1, 4,   1, 1'b0};
    vecs[10] = '{210, -1, 1'b1, 1'b0, 3, 2,   1, 1'b0};
    for (int i = 0; i < 11; i++) run_sweep(vecs[i], $sformatf("v%0d", i));

    // Reset while code 1 is being measured.
    stuck_code = -1;
    jitter_on  = 1'b0;
    @(negedge clk);
    target_cnt = CW'(180);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (alpha == 7'd1) begin
        got = 1'b1;
        break;
      end
    end
    chk("midrst reach_code1", 32'(got), 1);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst en", 32'(en), 0);
    chk("midrst alpha", 32'(alpha), 4);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst best_err", 32'(best_err), MAXE);
    chk("midrst done", 32'(done), 0);
    dcount = 0;
    repeat (1500) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst no_done", dcount, 0);
    chk("midrst still_idle", 32'(busy), 0);

    // start coincident with rst: reset wins.
    @(negedge clk);
    rst        = 1'b1;
    start      = 1'b1;
    target_cnt = CW'(180);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start busy", 32'(busy), 0);
    chk("rst_start en", 32'(en), 0);
    chk("rst_start alpha", 32'(alpha), 4);
    @(negedge clk);
    chk("rst_start idle", 32'(busy), 0);

    run_sweep(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
